// File: rtl/ad9866_spi_pkg.sv
// ad9866_spi_pkg: shared constants, frame field positions and FSM states for the AD9866 SPI responder
package ad9866_spi_pkg;

    localparam int FRAME_BITS = 16;
    localparam int HDR_BITS   = 8;
    localparam int ADDR_W     = 5;
    localparam int DATA_W     = 8;

    localparam int RW_BIT  = 15;
    localparam int BC_HI   = 14;
    localparam int BC_LO   = 13;
    localparam int ADDR_HI = 12;
    localparam int ADDR_LO = 8;
    localparam int DATA_HI = 7;
    localparam int DATA_LO = 0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ad9866_spi_responder_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for one asynchronous pin with registered edge strobes
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] s;
    logic              prev;

    assign level = s[STAGES-1];

    // Shift the pin through the chain; the chain resets low so a line already low at reset release shows no falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s    <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s    <= {s[STAGES-2:0], d};
            prev <= level;
            rise <= level & ~prev;
            fall <= ~level & prev;
        end
    end

endmodule

// File: rtl/ad9866_spi_responder.sv
// ad9866_spi_responder: AD9866 serial config port responder with local register file and read-back
module ad9866_spi_responder
    import ad9866_spi_pkg::*;
#(
    parameter int NREGS       = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        sen_n,
    input  logic        sdio,
    output logic        sdo,
    output logic        wr_valid,
    output logic [4:0]  wr_addr,
    output logic [7:0]  wr_data,
    input  logic [4:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic [7:0]  frame_err
);

    localparam logic [ADDR_W:0] NREGS_W = NREGS[ADDR_W:0];

    logic                    sclk_lvl, sclk_rise, sclk_fall;
    logic                    sen_lvl, sen_rise, sen_fall;
    logic                    sdio_lvl, sdio_rise, sdio_fall;
    logic                    unused_edges;
    logic [1:0]              state;
    logic [4:0]              cnt;
    logic [FRAME_BITS-2:0]   sh;
    logic [FRAME_BITS-1:0]   sh_nxt;
    logic                    hdr_rw;
    logic [DATA_W-1:0]       sdo_sr;
    logic [DATA_W-1:0]       preload;
    logic [DATA_W-1:0]       regs [2**ADDR_W];
    logic [ADDR_W-1:0]       hdr_addr;
    logic [ADDR_W-1:0]       f_addr;
    logic [DATA_W-1:0]       f_data;
    logic                    f_rw, f_bc_ok;
    logic                    in_frame, hdr_done, frm_done, abort, commit, reject;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NREGS_W;
    endfunction

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sen (
        .clk(clk), .rst_n(rst_n), .d(sen_n), .level(sen_lvl), .rise(sen_rise), .fall(sen_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sdio (
        .clk(clk), .rst_n(rst_n), .d(sdio), .level(sdio_lvl), .rise(sdio_rise), .fall(sdio_fall)
    );

    assign unused_edges = ^{sclk_lvl, sen_rise, sdio_rise, sdio_fall};

    // Frame decode works on the shift register including the bit arriving on this rise
    always_comb begin
        sh_nxt   = {sh, sdio_lvl};
        hdr_addr = sh_nxt[ADDR_HI-DATA_W:ADDR_LO-DATA_W];
        f_rw     = sh_nxt[RW_BIT];
        f_bc_ok  = sh_nxt[BC_HI:BC_LO] == 2'b00;
        f_addr   = sh_nxt[ADDR_HI:ADDR_LO];
        f_data   = sh_nxt[DATA_HI:DATA_LO];
        in_frame = (state == HDR) || (state == DATA);
        abort    = in_frame && sen_lvl;
        hdr_done = (state == HDR) && sclk_rise && !sen_lvl && (cnt == 5'(HDR_BITS - 1));
        frm_done = (state == DATA) && sclk_rise && !sen_lvl && (cnt == 5'(FRAME_BITS - 1));
        commit   = frm_done && !f_rw && f_bc_ok && in_range(f_addr);
        reject   = frm_done && !f_bc_ok;
        preload  = (sh_nxt[RW_BIT-DATA_W] && in_range(hdr_addr)) ? regs[hdr_addr] : '0;
    end

    // Frame sequencing: count bits on sclk rises, latch direction after the header, park in DONE until sen_n releases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sh     <= '0;
            hdr_rw <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
        end else if (state == IDLE) begin
            cnt   <= '0;
            state <= sen_fall ? HDR : IDLE;
        end else if (in_frame && sclk_rise) begin
            sh  <= sh_nxt[FRAME_BITS-2:0];
            cnt <= cnt + 5'd1;
            if (hdr_done) begin
                state  <= DATA;
                hdr_rw <= sh_nxt[RW_BIT-DATA_W];
            end
            if (frm_done) state <= DONE;
        end else if (state == DONE && sen_lvl) begin
            state <= IDLE;
        end
    end

    // Read data path: preload at header end, shift out MSB first on each sclk fall during a read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdo_sr <= '0;
            sdo    <= 1'b0;
        end else if (hdr_done) begin
            sdo_sr <= preload;
            sdo    <= 1'b0;
        end else if (state == DATA && hdr_rw && !sen_lvl) begin
            if (sclk_fall) begin
                sdo    <= sdo_sr[DATA_W-1];
                sdo_sr <= {sdo_sr[DATA_W-2:0], 1'b0};
            end
        end else begin
            sdo <= 1'b0;
        end
    end

    // Register file: flops so reset clears everything and the read preload needs no extra cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[f_addr] <= f_data;
        end
    end

    // Write notification: one-cycle strobe, address and data held until the next commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_valid <= commit;
            if (commit) begin
                wr_addr <= f_addr;
                wr_data <= f_data;
            end
        end
    end

    // Local read port: registered, sees the pre-write value in the commit cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= in_range(rd_addr) ? regs[rd_addr] : '0;
    end

    // Rejected-frame counter: aborts and bad byte counts, saturating at 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              frame_err <= '0;
        else if (abort || reject) frame_err <= sat_inc(frame_err);
    end

endmodule

// File: tb/tb_ad9866_spi_responder.sv
// tb_ad9866_spi_responder: directed frames with a write scoreboard checked by an independent monitor
module tb_ad9866_spi_responder;

    logic       clk = 1'b0;
    logic       rst_n, sclk, sen_n, sdio, sdo, wr_valid;
    logic [4:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data, frame_err;
    logic [7:0] rb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] old;
    } wr_t;

    wr_t        q[$];
    logic [7:0] mdl [32];

    always #5 clk = ~clk;

    ad9866_spi_responder #(.NREGS(20), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .sen_n(sen_n), .sdio(sdio), .sdo(sdo),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .frame_err(frame_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [7:0] d);
        q.push_back('{a, d, mdl[a]});
        mdl[a] = d;
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_sdo"}, sdo, 0);
        chk({tag, "_wr_valid"}, wr_valid, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        outputs_zero("mid_reset");
        for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
        rst_n = 1'b1;
    endtask

    // Master side: sdio changes while sclk is low, sdo sampled just before rises 9..16
    task automatic frame(input logic [15:0] f, input int nbits, input int half, input int rst_at,
                         output logic [7:0] rdb);
        logic [7:0] r;
        r = 8'h00;
        sen_n = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sdio = (i < 16) ? f[15-i] : 1'b0;
            repeat (half) @(negedge clk);
            if (i >= 8 && i < 16) r = {r[6:0], sdo};
            sclk = 1'b1;
            repeat (half) @(negedge clk);
            sclk = 1'b0;
            if (i + 1 == rst_at) do_reset();
        end
        repeat (half) @(negedge clk);
        sen_n = 1'b1;
        repeat (2 * half) @(negedge clk);
        rdb = r;
    endtask

    task automatic local_rd(input logic [4:0] a, input logic [7:0] exp, input string nm);
        rd_addr = a;
        repeat (2) @(negedge clk);
        chk(nm, rd_data, exp);
    endtask

    // Monitor: every wr_valid pops one expected write; also checks pulse width and old/new local read
    initial begin : mon
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && wr_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: got addr %0h data %0h, required no write", wr_addr, wr_data);
                end else begin
                    e = q.pop_front();
                    chk("wr_addr", wr_addr, e.a);
                    chk("wr_data", wr_data, e.d);
                    if (rd_addr == e.a) chk("rd_old_same_cycle", rd_data, e.old);
                    @(negedge clk);
                    chk("wr_pulse_len", wr_valid, 0);
                    if (rd_addr == e.a) chk("rd_new_next_cycle", rd_data, e.d);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; sclk = 1'b0; sen_n = 1'b1; sdio = 1'b0; rd_addr = 5'h00;
        for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
        repeat (3) @(negedge clk);
        outputs_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        outputs_zero("post_reset");

        rd_addr = 5'h0A;
        expect_wr(5'h0A, 8'h73);
        frame(16'h0A73, 16, 8, 0, rb);
        local_rd(5'h0A, 8'h73, "rd_0a");
        chk("err_after_write", frame_err, 0);

        expect_wr(5'h05, 8'hC3);
        frame(16'h05C3, 16, 8, 0, rb);
        frame(16'h8500, 16, 8, 0, rb);
        chk("sdo_read_05", rb, 8'hC3);
        chk("err_after_read", frame_err, 0);

        frame(16'h0211, 11, 8, 0, rb);
        chk("err_abort", frame_err, 1);
        local_rd(5'h02, 8'h00, "rd_02_after_abort");

        frame(16'h22FF, 16, 8, 0, rb);
        chk("err_bad_bc_write", frame_err, 2);
        local_rd(5'h02, 8'h00, "rd_02_after_bad_bc");

        frame(16'h1F55, 16, 8, 0, rb);
        chk("err_oor_write", frame_err, 2);
        frame(16'h9F00, 16, 8, 0, rb);
        chk("sdo_read_oor", rb, 8'h00);
        local_rd(5'h1F, 8'h00, "rd_1f");
        local_rd(5'h05, 8'hC3, "rd_05");

        frame(16'hA500, 16, 8, 0, rb);
        chk("err_bad_bc_read", frame_err, 3);

        for (int k = 0; k < 253; k++) frame(16'h22FF, 16, 5, 0, rb);
        chk("err_saturated", frame_err, 255);
        frame(16'h22FF, 16, 5, 0, rb);
        chk("err_no_wrap", frame_err, 255);

        rd_addr = 5'h07;
        frame(16'h0711, 16, 8, 12, rb);
        chk("err_after_reset_frame", frame_err, 0);
        local_rd(5'h07, 8'h00, "rd_07_after_reset");
        local_rd(5'h0A, 8'h00, "rd_0a_cleared");

        rd_addr = 5'h07;
        expect_wr(5'h07, 8'h66);
        frame(16'h0766, 20, 8, 0, rb);
        chk("err_after_20_pulses", frame_err, 0);
        local_rd(5'h07, 8'h66, "rd_07");

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ad9866_spi_responder.md
# ad9866_spi_responder

Responder (slave) end of the AD9866 3-wire-plus-SDO serial configuration port. It decodes 16-bit frames from the existing AD9866 SPI master into a local register file and returns register contents on reads. It stands in for the AD9866 when no expansion board is fitted, and serves as the loopback target for the configuration path in system benches. It sits beside the core on the `ad9866_sclk` / `ad9866_sdio` / `ad9866_sdo` / `ad9866_sen_n` nets.

## Interface
Parameters:
- `NREGS`, 20: implemented registers, addresses 0x00..NREGS-1; legal range 1..32.
- `SYNC_STAGES`, 2: synchronizer depth on `sclk`, `sen_n` and `sdio`; minimum 2.

Ports:
- `clk`, in, 1: system clock, the only clock in the block.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sclk`, in, 1: serial clock from the master, asynchronous to `clk`.
- `sen_n`, in, 1: frame enable, active low.
- `sdio`, in, 1: serial data from the master, MSB first.
- `sdo`, out, 1: serial read data to the master.
- `wr_valid`, out, 1: one-cycle pulse when a write commits.
- `wr_addr`, out, 5: address of the committed write.
- `wr_data`, out, 8: data of the committed write.
- `rd_addr`, in, 5: local read address.
- `rd_data`, out, 8: registered local read data.
- `frame_err`, out, 8: saturating count of rejected frames.

## Operation
- Frame layout, MSB first, 16 bits:
  - bit15: R/W, 1 = read.
  - bits14:13: byte count, must be 00.
  - bits12:8: address.
  - bits7:0: write data; ignored for reads.
- Input conditioning: `sclk`, `sen_n` and `sdio` pass through SYNC_STAGES flops. Edge detection on the synchronized `sclk` produces single-cycle `rise` and `fall` strobes.
- State machine:
  - IDLE: entered from reset. Goes to HDR on the synchronized falling edge of `sen_n`. Clears the bit counter.
  - HDR: on each `rise`, shifts `sdio` into the shift register and increments the counter. At count 8 it latches the header. A read to a valid address preloads the `sdo` shift register with reg[addr]; a read to an address ≥ NREGS preloads 0x00. Then goes to DATA.
  - DATA: on each `rise`, shifts in and increments the counter. For a read, each `fall` shifts the `sdo` register left and drives its MSB. At count 16 goes to DONE.
  - DONE:
    - Write with byte count 00 and addr < NREGS: updates reg[addr] and pulses `wr_valid` with `wr_addr`/`wr_data` for exactly one cycle.
    - Write with addr ≥ NREGS: dropped silently, no error.
    - Byte count ≠ 00: frame rejected and `frame_err` increments; applies to reads and writes.
    - Stays in DONE, ignoring further `rise`/`fall`, until `sen_n` deasserts, then returns to IDLE.
- Abort: `sen_n` deasserting in HDR or DATA (count < 16) discards the frame, increments `frame_err`, and returns to IDLE. No register changes.
- `sdo` is 0 outside the DATA state of a read.
- `frame_err` saturates at 255 and never wraps.
- Local read: `rd_data` <= reg[`rd_addr`] every cycle; returns 0x00 for `rd_addr` ≥ NREGS.
- A serial write and a local read in the same cycle: `rd_data` shows the old value and the new value one cycle later.

## Timing
- Reset values: all registers 0x00, `sdo` 0, `wr_valid` 0, `wr_addr` 0, `wr_data` 0, `rd_data` 0, `frame_err` 0, state IDLE.
- Reset mid-frame aborts with no error count. A frame already in progress when reset deasserts is ignored until `sen_n` is seen high.
- `rise`/`fall` assert SYNC_STAGES+1 `clk` cycles after the pin edge.
- `wr_valid` asserts in the cycle after the `rise` of bit 16.
- `sdo` updates in the cycle after `fall`, so it is stable SYNC_STAGES+2 cycles after the pin falling edge.
- Required master timing: `sclk` high and low each ≥ SYNC_STAGES+3 `clk` cycles. `sen_n` setup and hold around the first and last `sclk` edge ≥ SYNC_STAGES+1 cycles.
- Local read latency: 1 cycle.

## Structure
- Package `ad9866_spi_pkg`:
  - Constants `FRAME_BITS`=16, `HDR_BITS`=8, `ADDR_W`=5, `DATA_W`=8.
  - Field bit positions.
  - State enum {IDLE, HDR, DATA, DONE}.
- Sub-module `spi_sync_edge`: a parameterised SYNC_STAGES synchronizer plus edge detector, instantiated once per input. It exposes `level`, `rise`, `fall`.
- Register file: flops, not RAM, to keep reset values and zero-latency preload.

## Test plan
- Write 0x0A73: frame {0,00,0x0A,0x73} with `sclk`=8 clk cycles/half-period -> one `wr_valid` pulse, `wr_addr`=0x0A, `wr_data`=0x73; local read of 0x0A returns 0x73 one cycle later.
- Read-back: write 0x05=0xC3, then read frame {1,00,0x05,xx} -> `sdo` bits sampled on `sclk` rises 9..16 = 1100_0011; no `wr_valid`.
- Abort: `sen_n` raised after 11 bits -> no `wr_valid`, register unchanged, `frame_err`=1.
- Bad byte count: write frame {0,01,0x02,0xFF} -> rejected, `frame_err` increments, reg 0x02 unchanged; 260 such frames -> `frame_err`=255.
- Out of range: write 0x1F (NREGS=20) -> no `wr_valid`, no error; read 0x1F -> `sdo` all zeros.
- Reset mid-DATA plus extra clocks: `rst_n` low at bit 12, all outputs 0; frame with 20 `sclk` pulses -> only first 16 decoded, exactly one `wr_valid`.
